// File: rtl/dbi_tx_pkg.sv
// Shared types and default timing for the DBI Type-B write transmitter.
// FSM states, DCX encodings and the phase-counter sizing helper live here.
package dbi_tx_pkg;

  localparam int unsigned DBI_IF_D_W_DEF  = 8;
  localparam int unsigned WR_LOW_CYC_DEF  = 2;
  localparam int unsigned WR_HIGH_CYC_DEF = 2;
  localparam int unsigned CS_IDLE_CYC_DEF = 16;

  localparam logic DCX_CMD  = 1'b0;
  localparam logic DCX_DATA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WR_LOW,
    ST_WR_HIGH,
    ST_HOLD
  } dbi_state_e;

  // Largest of the three phase lengths; sizes the shared phase counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/dbi_tx_if.sv
// Byte/command handshake plus DBI pin bundle between the transmitter and its neighbours.
// The slave side is the transmitter; the master side feeds bytes and watches the pins.
interface dbi_tx_if
  import dbi_tx_pkg::*;
#(
  parameter int unsigned DBI_IF_D_W = DBI_IF_D_W_DEF
);

  logic [DBI_IF_D_W-1:0] cmd_data_i;
  logic                  cmd_vld_i;
  logic                  cmd_rdy_o;
  logic [DBI_IF_D_W-1:0] d_data_i;
  logic                  d_vld_i;
  logic                  d_rdy_o;
  logic                  dbi_csx_o;
  logic                  dbi_dcx_o;
  logic                  dbi_wrx_o;
  logic                  dbi_rdx_o;
  logic [DBI_IF_D_W-1:0] dbi_d_o;
  logic                  busy_o;

  modport slave (
    input  cmd_data_i, cmd_vld_i, d_data_i, d_vld_i,
    output cmd_rdy_o, d_rdy_o,
    output dbi_csx_o, dbi_dcx_o, dbi_wrx_o, dbi_rdx_o, dbi_d_o, busy_o
  );

  modport master (
    output cmd_data_i, cmd_vld_i, d_data_i, d_vld_i,
    input  cmd_rdy_o, d_rdy_o,
    input  dbi_csx_o, dbi_dcx_o, dbi_wrx_o, dbi_rdx_o, dbi_d_o, busy_o
  );

endinterface

// File: rtl/dbi_tx_phy.sv
// DBI Type-B (8080-style) write-only transmitter: command/data bytes onto CSX/DCX/WRX/D.
// Every dbi_* pin and the ready/busy flags come straight from flops; only d_rdy_o sees cmd_vld_i.
module dbi_tx_phy
  import dbi_tx_pkg::*;
#(
  parameter int unsigned DBI_IF_D_W  = DBI_IF_D_W_DEF,
  parameter int unsigned WR_LOW_CYC  = WR_LOW_CYC_DEF,
  parameter int unsigned WR_HIGH_CYC = WR_HIGH_CYC_DEF,
  parameter int unsigned CS_IDLE_CYC = CS_IDLE_CYC_DEF
) (
  input logic      clk,
  input logic      rst_n,
  dbi_tx_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(max3(WR_LOW_CYC, WR_HIGH_CYC, CS_IDLE_CYC) + 1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] WR_LOW_LD  = CNT_W'(WR_LOW_CYC);
  localparam logic [CNT_W-1:0] WR_HIGH_LD = CNT_W'(WR_HIGH_CYC);
  localparam logic [CNT_W-1:0] CS_IDLE_LD = CNT_W'(CS_IDLE_CYC);

  dbi_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   win_q, win_d;
  logic                   csx_q, csx_d;
  logic                   wrx_q, wrx_d;
  logic                   busy_q, busy_d;
  logic                   dcx_q;
  logic [DBI_IF_D_W-1:0]  d_q;

  logic                   acc_cmd;
  logic                   acc_dat;
  logic                   accept;
  logic                   load_dcx;
  logic [DBI_IF_D_W-1:0]  load_byte;

  // Handshake: win_q marks IDLE, HOLD or the final WR_HIGH cycle; commands win over data.
  assign acc_cmd   = win_q & bus.cmd_vld_i;
  assign acc_dat   = win_q & ~bus.cmd_vld_i & bus.d_vld_i;
  assign accept    = acc_cmd | acc_dat;
  assign load_dcx  = acc_cmd ? DCX_CMD : DCX_DATA;
  assign load_byte = acc_cmd ? bus.cmd_data_i : bus.d_data_i;

  // Next state, phase counter and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = 1'b0;
    csx_d   = 1'b1;
    wrx_d   = 1'b1;
    busy_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SETUP;
          cnt_d   = CNT_ONE;
        end
      end
      ST_SETUP: begin
        state_d = ST_WR_LOW;
        cnt_d   = WR_LOW_LD;
      end
      ST_WR_LOW: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_WR_HIGH;
          cnt_d   = WR_HIGH_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_WR_HIGH: begin
        if (cnt_q == CNT_ONE) begin
          if (accept) begin
            state_d = ST_WR_LOW;
            cnt_d   = WR_LOW_LD;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        // A byte arriving on the timeout cycle still wins, so CSX never glitches high.
        if (accept) begin
          state_d = ST_WR_LOW;
          cnt_d   = WR_LOW_LD;
        end else if (cnt_q == CS_IDLE_LD) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    win_d  = (state_d == ST_IDLE) || (state_d == ST_HOLD) ||
             ((state_d == ST_WR_HIGH) && (cnt_d == CNT_ONE));
    csx_d  = (state_d == ST_IDLE);
    wrx_d  = (state_d != ST_WR_LOW);
    busy_d = (state_d != ST_IDLE);
  end

  // State and pin registers; D/DCX change only on an accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      win_q   <= 1'b0;
      csx_q   <= 1'b1;
      wrx_q   <= 1'b1;
      busy_q  <= 1'b0;
      dcx_q   <= DCX_DATA;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      csx_q   <= csx_d;
      wrx_q   <= wrx_d;
      busy_q  <= busy_d;
      if (accept) begin
        dcx_q <= load_dcx;
        d_q   <= load_byte;
      end
    end
  end

  assign bus.cmd_rdy_o = win_q;
  assign bus.d_rdy_o   = win_q & ~bus.cmd_vld_i;
  assign bus.dbi_csx_o = csx_q;
  assign bus.dbi_dcx_o = dcx_q;
  assign bus.dbi_wrx_o = wrx_q;
  assign bus.dbi_rdx_o = 1'b1;
  assign bus.dbi_d_o   = d_q;
  assign bus.busy_o    = busy_q;

endmodule
